time_set_sequencer: RTL and testbench

- Front-end controller for the clock's setting path; sits between the raw push-buttons and the hours/minutes/seconds counters.
- Synchronizes and debounces two buttons: mode (set) and advance (adv).
- Runs a RUN -> SET_HOURS -> SET_MINUTES -> RUN mode machine.
- Emits one-cycle increment strobes to the hours and minutes counters, a seconds-clear strobe, a freeze level and a display blink.

---
 rtl/time_set_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_time_set_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_sequencer.sv
// ============================================================================
//  Module   : time_set_sequencer
//  Purpose  : Front-end controller for the clock setting path. Synchronises and
//             debounces the mode (set) and advance (adv) buttons, runs the
//             RUN -> SET_HOURS -> SET_MINUTES -> RUN mode machine and emits
//             registered one-cycle strobes for the time counters.
//  Ports    : project_clk  in   sole clock
//             rst          in   asynchronous active-low reset
//             tick_1hz     in   one-cycle 1 Hz strobe (project_clk domain)
//             set, adv     in   raw asynchronous push-buttons, active-high
//             setting      out  high while in a set mode (freezes seconds)
//             inc_h, inc_m out  one-cycle hours / minutes increment strobes
//             clr_s        out  one-cycle seconds-clear strobe
//             mode         out  00 RUN, 01 SET_HOURS, 10 SET_MINUTES
//             blink        out  blank phase for the field being set
//  Macro    : TIME_SET_AUTO_REPEAT_EN enables auto-repeat while adv is held.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module time_set_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TIMEOUT_S       = 8'd10,
  parameter logic [23:0] REPEAT_DELAY    = 24'd25000000,
  parameter logic [23:0] REPEAT_RATE     = 24'd5000000
) (
  input  logic       project_clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       set,
  input  logic       adv,
  output logic       setting,
  output logic       inc_h,
  output logic       inc_m,
  output logic       clr_s,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [1:0] c_RUN   = 2'b00;
  localparam logic [1:0] c_SET_H = 2'b01;
  localparam logic [1:0] c_SET_M = 2'b10;

  logic [1:0] w_raw;
  logic [1:0] w_press;
  logic       w_set_press;
  logic       w_adv_press;
  logic       w_in_set;
  logic       w_to_hit;
  logic       w_repeat;
  logic       w_adv_acc;
  logic       w_expire;

  logic [1:0] mode_q,    mode_d;
  logic       setting_q, setting_d;
  logic       inc_h_q,   inc_h_d;
  logic       inc_m_q,   inc_m_d;
  logic       clr_s_q,   clr_s_d;
  logic       blink_q,   blink_d;
  logic [7:0] to_cnt_q,  to_cnt_d;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = set, bit 1 = adv
  // --------------------------------------------------------------------------
  assign w_raw = {adv, set};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic        sync1_q;
    logic        sync2_q;
    logic        deb_q;
    logic        deb_prev_q;
    logic [15:0] cnt_q;

    always_ff @(posedge project_clk or negedge rst) begin
      if (!rst) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= w_raw[gi];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        // Any return to the debounced level restarts the stability window
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end

    assign w_press[gi] = deb_q & ~deb_prev_q;
  end

  assign w_set_press = w_press[0];
  assign w_adv_press = w_press[1];
  assign w_in_set    = (mode_q != c_RUN);

  // Expiry is evaluated on the tick that would take the count to TIMEOUT_S
  assign w_to_hit = w_in_set & tick_1hz &
                    (({1'b0, to_cnt_q} + 9'd1) >= {1'b0, TIMEOUT_S});

  // --------------------------------------------------------------------------
  // Auto-repeat
  // --------------------------------------------------------------------------
`ifdef TIME_SET_AUTO_REPEAT_EN
  logic        w_adv_held;
  logic [23:0] w_hold_target;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic        rep_phase_q, rep_phase_d;

  assign w_adv_held    = g_btn[1].deb_q;
  // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE
  assign w_hold_target = rep_phase_q ? REPEAT_RATE : REPEAT_DELAY;

  always_comb begin
    w_repeat    = 1'b0;
    hold_cnt_d  = '0;
    rep_phase_d = 1'b0;
    // A set press or a timeout expiry changes mode, which clears the hold
    if (w_adv_held && w_in_set && !w_set_press) begin
      if (hold_cnt_q == w_hold_target) begin
        w_repeat    = 1'b1;
        hold_cnt_d  = 24'd1;
        rep_phase_d = 1'b1;
      end else if (!w_to_hit || w_adv_press) begin
        hold_cnt_d  = hold_cnt_q + 24'd1;
        rep_phase_d = rep_phase_q;
      end
    end
  end

  always_ff @(posedge project_clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  logic w_repeat_unused;
  assign w_repeat        = 1'b0;
  assign w_repeat_unused = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // set always wins over adv; accepted adv (press or repeat) wins over expiry
  assign w_adv_acc = w_in_set & ~w_set_press & (w_adv_press | w_repeat);
  assign w_expire  = w_to_hit & ~w_set_press & ~w_adv_acc;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge project_clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= c_RUN;
      setting_q <= 1'b0;
      inc_h_q   <= 1'b0;
      inc_m_q   <= 1'b0;
      clr_s_q   <= 1'b0;
      blink_q   <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      setting_q <= setting_d;
      inc_h_q   <= inc_h_d;
      inc_m_q   <= inc_m_d;
      clr_s_q   <= clr_s_d;
      blink_q   <= blink_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      c_RUN:   if (w_set_press) mode_d = c_SET_H;
      c_SET_H: if (w_set_press) mode_d = c_SET_M;
               else if (w_expire) mode_d = c_RUN;
      c_SET_M: if (w_set_press || w_expire) mode_d = c_RUN;
      default: mode_d = c_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (registered by the state register)
  // --------------------------------------------------------------------------
  always_comb begin
    inc_h_d   = (mode_q == c_SET_H) & w_adv_acc;
    inc_m_d   = (mode_q == c_SET_M) & w_adv_acc;
    clr_s_d   = (mode_q == c_SET_M) & (mode_d == c_RUN);
    setting_d = (mode_d != c_RUN);

    blink_d = blink_q;
    if ((mode_d == c_RUN) || (mode_d != mode_q)) begin
      blink_d = 1'b0;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end

    to_cnt_d = to_cnt_q;
    if ((mode_d == c_RUN) || (mode_d != mode_q) || w_adv_acc) begin
      to_cnt_d = '0;
    end else if (tick_1hz && (to_cnt_q != 8'hFF)) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
  end

  assign mode    = mode_q;
  assign setting = setting_q;
  assign inc_h   = inc_h_q;
  assign inc_m   = inc_m_q;
  assign clr_s   = clr_s_q;
  assign blink   = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_time_set_sequencer.sv
// ============================================================================
//  Module   : tb_time_set_sequencer
//  Purpose  : Scoreboard bench for time_set_sequencer. Stimulus pushes the
//             expected output event (cycle, mode and strobes); a monitor pops
//             and compares whenever the DUT shows a strobe or a mode change.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_set_sequencer;

  logic       project_clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       set;
  logic       adv;
  logic       setting;
  logic       inc_h;
  logic       inc_m;
  logic       clr_s;
  logic [1:0] mode;
  logic       blink;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       setting;
    logic       inc_h;
    logic       inc_m;
    logic       clr_s;
  } ev_t;

  ev_t exp_q[$];

  time_set_sequencer #(
    .DEBOUNCE_CYCLES(16'd4),
    .TIMEOUT_S      (8'd3),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_RATE    (24'd5)
  ) dut (
    .project_clk(project_clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .set        (set),
    .adv        (adv),
    .setting    (setting),
    .inc_h      (inc_h),
    .inc_m      (inc_m),
    .clr_s      (clr_s),
    .mode       (mode),
    .blink      (blink)
  );

  always #5 project_clk = ~project_clk;
  always @(posedge project_clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic [1:0] prev_mode;
    logic       prev_setting;
    ev_t        e;
    prev_mode    = 2'b00;
    prev_setting = 1'b0;
    forever begin
      @(posedge project_clk);
      #1;
      if (!rst) begin
        prev_mode    = 2'b00;
        prev_setting = 1'b0;
      end else begin
        tests++;
        if ((int'(inc_h) + int'(inc_m) + int'(clr_s)) > 1 || (inc_h && mode == 2'b10)) begin
          fails++;
          $display("FAIL strobe_excl cyc=%0d got inc_h=%b inc_m=%b clr_s=%b mode=%b, want at most one strobe and no inc_h in mode 10",
                   cyc, inc_h, inc_m, clr_s, mode);
        end
        if (inc_h || inc_m || clr_s || mode != prev_mode || setting != prev_setting) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event cyc=%0d got mode=%b setting=%b inc_h=%b inc_m=%b clr_s=%b, want no event",
                     cyc, mode, setting, inc_h, inc_m, clr_s);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.mode != mode || e.setting != setting ||
                e.inc_h != inc_h || e.inc_m != inc_m || e.clr_s != clr_s) begin
              fails++;
              $display("FAIL event got cyc=%0d mode=%b setting=%b inc_h=%b inc_m=%b clr_s=%b, want cyc=%0d mode=%b setting=%b inc_h=%b inc_m=%b clr_s=%b",
                       cyc, mode, setting, inc_h, inc_m, clr_s,
                       e.cyc, e.mode, e.setting, e.inc_h, e.inc_m, e.clr_s);
            end
          end
        end
        prev_mode    = mode;
        prev_setting = setting;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called and returning at a negedge)
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge project_clk);
  endtask

  task automatic push(input int dly, input logic [1:0] m, input logic st,
                      input logic h, input logic mi, input logic c);
    ev_t e;
    e.cyc     = cyc + dly;
    e.mode    = m;
    e.setting = st;
    e.inc_h   = h;
    e.inc_m   = mi;
    e.clr_s   = c;
    exp_q.push_back(e);
  endtask

  // Raw edge at this negedge reaches the outputs 2 + 4 + 1 = 7 edges later
  task automatic press(input logic s, input logic a, input logic want,
                       input logic [1:0] m, input logic st, input logic h,
                       input logic mi, input logic c, input int hold);
    if (want) push(7, m, st, h, mi, c);
    set = s;
    adv = a;
    step(hold);
    set = 1'b0;
    adv = 1'b0;
    step(12);
  endtask

  task automatic tick(input logic exp_blink, input string name);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    tests++;
    if (blink !== exp_blink) begin
      fails++;
      $display("FAIL %s got blink=%b, want %b", name, blink, exp_blink);
    end
    step(2);
  endtask

  task automatic check_idle(input string name);
    tests++;
    if ({setting, inc_h, inc_m, clr_s, mode, blink} !== 7'd0) begin
      fails++;
      $display("FAIL %s got setting=%b inc_h=%b inc_m=%b clr_s=%b mode=%b blink=%b, want all 0",
               name, setting, inc_h, inc_m, clr_s, mode, blink);
    end
  endtask

  task automatic check_mode(input logic [1:0] m, input string name);
    tests++;
    if (mode !== m) begin
      fails++;
      $display("FAIL %s got mode=%b, want %b", name, mode, m);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s got %0d pending events, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst      = 1'b0;
    tick_1hz = 1'b0;
    set      = 1'b0;
    adv      = 1'b0;
    step(1);

    // Reset held with buttons toggling
    for (int i = 0; i < 5; i++) begin
      set = ~set;
      adv = ~adv;
      step(1);
      check_idle("reset_hold");
    end
    set = 1'b0;
    adv = 1'b0;
    step(1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_idle("reset_release");
    end

    // Bounce rejection
    for (int i = 0; i < 3; i++) begin
      set = 1'b1;
      step(2);
      set = 1'b0;
      step(3);
    end
    step(10);
    check_mode(2'b00, "bounce_reject");
    check_drained("bounce_reject_events");

    // Clean press: mode changes exactly 7 cycles after the raw edge
    push(7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    set = 1'b1;
    step(6);
    check_mode(2'b00, "latency_before");
    step(1);
    check_mode(2'b01, "latency_at_7");
    step(3);
    set = 1'b0;
    step(12);

    // Full set cycle
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    for (int i = 0; i < 2; i++) press(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_drained("full_cycle");

    // Timeout from SET_MINUTES: clr_s on expiry
    press(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    tests++;
    if (blink !== 1'b0) begin
      fails++;
      $display("FAIL blink_entry got blink=%b, want 0", blink);
    end
    tick(1'b1, "blink_tick1");
    tick(1'b0, "blink_tick2");
    push(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, "blink_expire_m");
    check_mode(2'b00, "timeout_m");
    check_drained("timeout_m_events");

    // Timeout from SET_HOURS: no clr_s
    press(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    tick(1'b1, "blink_h_tick1");
    tick(1'b0, "blink_h_tick2");
    push(1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, "blink_expire_h");
    check_mode(2'b00, "timeout_h");
    check_drained("timeout_h_events");

    // Simultaneous set and adv: set wins, no inc_h
    press(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    press(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    // adv in RUN is ignored
    press(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    check_drained("simultaneous");

    // Reset mid-setting abandons the set without clr_s
    press(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    rst = 1'b0;
    #1;
    check_idle("reset_mid_set");
    step(3);
    rst = 1'b1;
    step(3);
    check_idle("reset_mid_set_after");
    check_drained("reset_mid_set_events");

    // Adv held in SET_HOURS
    press(1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    push(7, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef TIME_SET_AUTO_REPEAT_EN
    push(27, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(37, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(42, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    adv = 1'b1;
    step(38);
    adv = 1'b0;
    step(15);
    check_drained("adv_hold");
    press(1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8);
    press(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    check_mode(2'b00, "final_mode");
    check_drained("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
